// File: rtl/coin_acceptor_if.sv
`default_nettype none
// ============================================================================
// Module : coin_acceptor_if
// Brief  : Sensor inputs and coin-code outputs of the coin acceptor front end.
// Rev    : 1.0  initial release
// ============================================================================
interface coin_acceptor_if;
  logic       sens5;
  logic       sens10;
  logic       accept_en;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic [2:0] state_present;

  // master: sensor / enable side; slave: the acceptor itself
  modport master (
    output sens5, sens10, accept_en,
    input  coin, reject, jam, state_present
  );

  modport slave (
    input  sens5, sens10, accept_en,
    output coin, reject, jam, state_present
  );
endinterface
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module : coin_acceptor
// Brief  : Synchronizes, debounces and locks out two coin chutes; emits a
//          one-cycle coin code, reject pulse, or jam level.
// Rev    : 1.0  initial release
// ============================================================================
module coin_acceptor #(
  parameter int DEB_CYCLES     = 4,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int JAM_CYCLES     = 64
) (
  input  logic            clk,
  input  logic            rst,
  coin_acceptor_if.slave  bus
);

  localparam int c_MAX_DL  = (DEB_CYCLES > LOCKOUT_CYCLES) ? DEB_CYCLES : LOCKOUT_CYCLES;
  localparam int c_MAX_ALL = (c_MAX_DL > JAM_CYCLES) ? c_MAX_DL : JAM_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_ALL + 1);

  localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [c_CNT_W-1:0] c_DEB_LAST  = c_CNT_W'(DEB_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_JAM_LAST  = c_CNT_W'(JAM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_QUAL     = 3'd1,
    S_EMIT     = 3'd2,
    S_WAIT_REL = 3'd3,
    S_LOCK     = 3'd4,
    S_JAM      = 3'd5
  } state_e;

  state_e               state_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic [c_CNT_W-1:0]   cnt_inc_d;
  logic [1:0]           sync5_q;
  logic [1:0]           sync10_q;
  logic                 sel_q;      // 0 = 5-unit coin, 1 = 10-unit coin
  logic [1:0]           coin_q;
  logic                 reject_q;
  logic                 jam_q;
  logic                 s5;
  logic                 s10;
  logic                 sel_hi;
  logic                 other_hi;

  assign s5        = sync5_q[1];
  assign s10       = sync10_q[1];
  assign sel_hi    = sel_q ? s10 : s5;
  assign other_hi  = sel_q ? s5 : s10;
  assign cnt_inc_d = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + c_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync5_q  <= 2'b00;
      sync10_q <= 2'b00;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      coin_q   <= 2'b00;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
    end else begin
      sync5_q  <= {sync5_q[0], bus.sens5};
      sync10_q <= {sync10_q[0], bus.sens10};
      coin_q   <= 2'b00;
      reject_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (s5 && s10) begin
            state_q <= S_JAM;
            cnt_q   <= '0;
            jam_q   <= 1'b1;
          end else if (s5) begin
            state_q <= S_QUAL;
            sel_q   <= 1'b0;
            cnt_q   <= c_ONE;
          end else if (s10) begin
            state_q <= S_QUAL;
            sel_q   <= 1'b1;
            cnt_q   <= c_ONE;
          end
        end
        S_QUAL: begin
          if (other_hi) begin
            state_q <= S_JAM;
            cnt_q   <= '0;
            jam_q   <= 1'b1;
          end else if (!sel_hi) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == c_DEB_LAST) begin
            // outputs are registered, so the EMIT-cycle pulse is loaded here
            state_q <= S_EMIT;
            if (bus.accept_en) coin_q <= sel_q ? 2'b10 : 2'b01;
            else               reject_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_EMIT: begin
          state_q <= S_WAIT_REL;
          cnt_q   <= '0;
        end
        S_WAIT_REL: begin
          if (!s5 && !s10) begin
            state_q <= S_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == c_JAM_LAST) begin
            state_q <= S_JAM;
            cnt_q   <= '0;
            jam_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_LOCK: begin
          if (cnt_q == c_LOCK_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_JAM: begin
          if (s5 || s10) begin
            cnt_q <= '0;
          end else if (cnt_q == c_DEB_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            jam_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          jam_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin          = coin_q;
  assign bus.reject        = reject_q;
  assign bus.jam           = jam_q;
  assign bus.state_present = state_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module : tb_coin_acceptor
// Brief  : Scoreboard bench for coin_acceptor at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEB_CYCLES     (4),
    .LOCKOUT_CYCLES (8),
    .JAM_CYCLES     (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [1:0] coin;
    logic       reject;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc          = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every coin/reject pulse must match the next scoreboard entry, cycle-exact
  always @(negedge clk) begin
    if (rst && (bus.coin !== 2'b00 || bus.reject !== 1'b0)) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse cyc=%0d coin=%b reject=%b, required no pulse",
                 cyc, bus.coin, bus.reject);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.coin !== mon_e.coin || bus.reject !== mon_e.reject || cyc !== mon_e.cyc) begin
          tests_failed++;
          $display("FAIL pulse got coin=%b reject=%b cyc=%0d, required coin=%b reject=%b cyc=%0d",
                   bus.coin, bus.reject, cyc, mon_e.coin, mon_e.reject, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 4;
    if (bus.coin !== 2'b00)          begin tests_failed++; $display("FAIL reset_coin got %b, required 00", bus.coin); end
    if (bus.reject !== 1'b0)         begin tests_failed++; $display("FAIL reset_reject got %b, required 0", bus.reject); end
    if (bus.jam !== 1'b0)            begin tests_failed++; $display("FAIL reset_jam got %b, required 0", bus.jam); end
    if (bus.state_present !== 3'd0)  begin tests_failed++; $display("FAIL reset_state got %0d, required 0", bus.state_present); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_accept_5();
    int n;
    n = cyc;
    bus.accept_en = 1'b1;
    bus.sens5 = 1'b1;
    exp_q.push_back('{2'b01, 1'b0, n + 6});
    repeat (10) @(negedge clk);
    bus.sens5 = 1'b0;
    tests_run++;
    if (bus.state_present !== 3'd3) begin tests_failed++; $display("FAIL accept5_waitrel got %0d, required 3", bus.state_present); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.state_present !== 3'd4) begin tests_failed++; $display("FAIL accept5_lock got %0d, required 4", bus.state_present); end
    repeat (8) @(negedge clk);
    tests_run += 3;
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL accept5_idle got %0d, required 0", bus.state_present); end
    if (bus.jam !== 1'b0)           begin tests_failed++; $display("FAIL accept5_jam got %b, required 0", bus.jam); end
    if (exp_q.size() != 0)          begin tests_failed++; $display("FAIL accept5_missing got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_glitch();
    bus.sens10 = 1'b1;
    repeat (3) @(negedge clk);
    bus.sens10 = 1'b0;
    tests_run++;
    if (bus.state_present !== 3'd1) begin tests_failed++; $display("FAIL glitch_qual got %0d, required 1", bus.state_present); end
    repeat (6) @(negedge clk);
    tests_run++;
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL glitch_idle got %0d, required 0", bus.state_present); end
  endtask

  task automatic test_reject();
    int n;
    n = cyc;
    bus.accept_en = 1'b0;
    bus.sens10 = 1'b1;
    exp_q.push_back('{2'b00, 1'b1, n + 6});
    repeat (10) @(negedge clk);
    bus.sens10 = 1'b0;
    repeat (15) @(negedge clk);
    bus.accept_en = 1'b1;
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL reject_missing got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_jam_both();
    int n;
    bus.sens5 = 1'b1;
    repeat (2) @(negedge clk);
    bus.sens10 = 1'b1;
    repeat (4) @(negedge clk);
    tests_run += 2;
    if (bus.jam !== 1'b1)           begin tests_failed++; $display("FAIL jam_set got %b, required 1", bus.jam); end
    if (bus.state_present !== 3'd5) begin tests_failed++; $display("FAIL jam_state got %0d, required 5", bus.state_present); end
    bus.sens5 = 1'b0;
    bus.sens10 = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.jam !== 1'b1) begin tests_failed++; $display("FAIL jam_hold got %b, required 1", bus.jam); end
    @(negedge clk);
    tests_run++;
    if (bus.jam !== 1'b0) begin tests_failed++; $display("FAIL jam_clear got %b, required 0", bus.jam); end
    n = cyc;
    bus.sens5 = 1'b1;
    exp_q.push_back('{2'b01, 1'b0, n + 6});
    repeat (10) @(negedge clk);
    bus.sens5 = 1'b0;
    repeat (14) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL jam_recover_missing got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stuck();
    int n;
    n = cyc;
    bus.sens5 = 1'b1;
    exp_q.push_back('{2'b01, 1'b0, n + 6});
    repeat (70) @(negedge clk);
    tests_run += 2;
    if (bus.jam !== 1'b0)           begin tests_failed++; $display("FAIL stuck_early got jam=%b, required 0", bus.jam); end
    if (bus.state_present !== 3'd3) begin tests_failed++; $display("FAIL stuck_waitrel got %0d, required 3", bus.state_present); end
    @(negedge clk);
    tests_run++;
    if (bus.jam !== 1'b1) begin tests_failed++; $display("FAIL stuck_jam got %b, required 1", bus.jam); end
    repeat (9) @(negedge clk);
    bus.sens5 = 1'b0;
    for (int i = 0; i < 20 && bus.jam; i++) @(negedge clk);
    tests_run += 2;
    if (bus.jam !== 1'b0)  begin tests_failed++; $display("FAIL stuck_release got jam=%b, required 0", bus.jam); end
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stuck_missing got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_qual();
    bus.sens5 = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.state_present !== 3'd1) begin tests_failed++; $display("FAIL rstq_qual got %0d, required 1", bus.state_present); end
    rst = 1'b0;
    bus.sens5 = 1'b0;
    @(negedge clk);
    tests_run += 3;
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL rstq_state got %0d, required 0", bus.state_present); end
    if (bus.coin !== 2'b00)         begin tests_failed++; $display("FAIL rstq_coin got %b, required 00", bus.coin); end
    if (dut.cnt_q !== '0)           begin tests_failed++; $display("FAIL rstq_cnt got %0d, required 0", dut.cnt_q); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL rstq_after got %0d, required 0", bus.state_present); end
  endtask

  task automatic test_lock_ignore();
    int n;
    n = cyc;
    bus.sens5 = 1'b1;
    exp_q.push_back('{2'b01, 1'b0, n + 6});
    repeat (10) @(negedge clk);
    bus.sens5 = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.state_present !== 3'd4) begin tests_failed++; $display("FAIL lock_state got %0d, required 4", bus.state_present); end
    bus.sens5 = 1'b1;
    repeat (3) @(negedge clk);
    bus.sens5 = 1'b0;
    repeat (10) @(negedge clk);
    tests_run += 2;
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL lock_idle got %0d, required 0", bus.state_present); end
    if (exp_q.size() != 0)          begin tests_failed++; $display("FAIL lock_missing got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int n;
    n = cyc;
    bus.sens5 = 1'b1;
    exp_q.push_back('{2'b01, 1'b0, n + 6});
    repeat (10) @(negedge clk);
    bus.sens5 = 1'b0;
    repeat (2) @(negedge clk);
    // second coin arrives during lockout and qualifies only once it ends
    bus.sens10 = 1'b1;
    exp_q.push_back('{2'b10, 1'b0, n + 25});
    repeat (15) @(negedge clk);
    bus.sens10 = 1'b0;
    repeat (20) @(negedge clk);
    tests_run += 2;
    if (exp_q.size() != 0)          begin tests_failed++; $display("FAIL b2b_missing got %0d pending, required 0", exp_q.size()); end
    if (bus.state_present !== 3'd0) begin tests_failed++; $display("FAIL b2b_idle got %0d, required 0", bus.state_present); end
  endtask

  initial begin
    bus.sens5     = 1'b0;
    bus.sens10    = 1'b0;
    bus.accept_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_accept_5();
    test_glitch();
    test_reject();
    test_jam_both();
    test_stuck();
    test_reset_mid_qual();
    test_lock_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
